// File: rtl/sound_cmd_latch.sv
// Sound-CPU end of the main->sound command path: command latch plus Z80 mode-0 INT/vector.
// Define SND_CMD_FIFO_EN to replace the single latch with a 2**FIFO_AW-entry command FIFO.
module sound_cmd_latch #(
  parameter logic [7:0] VEC_BASE = 8'hFF,
  parameter logic [7:0] VEC_YM   = 8'hEF,
  parameter logic [7:0] VEC_CMD  = 8'hDF
`ifdef SND_CMD_FIFO_EN
  , parameter int unsigned FIFO_AW = 2
`endif
) (
  input  logic       CLK_32M,
  input  logic       RESET_N,
  input  logic       CE_SND,
  input  logic [7:0] MAIN_DIN,
  input  logic       MAIN_WR,
  output logic       MAIN_BUSY,
  output logic [7:0] SND_DOUT,
  input  logic       SND_ACK,
  input  logic       SND_IACK,
  output logic [7:0] SND_VECTOR,
  output logic       SND_INT_N,
  input  logic       YM_IRQ_N,
  output logic       OVERRUN
);

  logic [1:0] ym_sync_q;
  logic       ym_pend;
  logic       pending;
  logic       busy_q, busy_d;
  logic       overrun_q, overrun_d;
  logic       int_n_q, int_n_d;
  logic [7:0] vec_q, vec_d;

  // YM IRQ is asynchronous to CLK_32M: two-flop synchroniser, idle high
  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) ym_sync_q <= 2'b11;
    else          ym_sync_q <= {ym_sync_q[0], YM_IRQ_N};
  end

  assign ym_pend = ~ym_sync_q[1];

`ifdef SND_CMD_FIFO_EN
  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               full, push, pop;

  // A full FIFO still accepts a push when the same cycle pops an entry
  always_comb begin
    full      = (count_q == CW'(DEPTH));
    pop       = SND_ACK && (count_q != '0);
    push      = MAIN_WR && (!full || pop);
    wr_ptr_d  = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    count_d   = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    overrun_d = overrun_q;
    if (count_d == '0)           overrun_d = 1'b0;
    else if (MAIN_WR && !push)   overrun_d = 1'b1;
    busy_d    = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= MAIN_DIN;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pending  = (count_q != '0);
  assign SND_DOUT = mem_q[rd_ptr_q];
`else
  logic       pending_q, pending_d;
  logic [7:0] data_q, data_d;

  // Write beats ack; an ack (alone or with a write) always clears overrun
  always_comb begin
    pending_d = pending_q;
    data_d    = data_q;
    overrun_d = overrun_q;
    if (MAIN_WR) begin
      data_d    = MAIN_DIN;
      pending_d = 1'b1;
      overrun_d = SND_ACK ? 1'b0 : (overrun_q | pending_q);
    end else if (SND_ACK) begin
      pending_d = 1'b0;
      overrun_d = 1'b0;
    end
    busy_d = pending_d;
  end

  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) begin
      pending_q <= 1'b0;
      data_q    <= 8'h00;
    end else begin
      pending_q <= pending_d;
      data_q    <= data_d;
    end
  end

  assign pending  = pending_q;
  assign SND_DOUT = data_q;
`endif

  // INT/vector move only on Z80 clock enables and hold through an IACK cycle
  always_comb begin
    vec_d   = vec_q;
    int_n_d = int_n_q;
    if (CE_SND && !SND_IACK) begin
      vec_d   = VEC_BASE & (ym_pend ? VEC_YM : 8'hFF) & (pending ? VEC_CMD : 8'hFF);
      int_n_d = ~(pending | ym_pend);
    end
  end

  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) begin
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      int_n_q   <= 1'b1;
      vec_q     <= VEC_BASE;
    end else begin
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      int_n_q   <= int_n_d;
      vec_q     <= vec_d;
    end
  end

  assign MAIN_BUSY  = busy_q;
  assign OVERRUN    = overrun_q;
  assign SND_INT_N  = int_n_q;
  assign SND_VECTOR = vec_q;

endmodule
